// File: rtl/hex_display_mux_if.sv
// Display bus for hex_display_mux: the count/blank inputs, the board-facing
// segment/anode outputs, and a debug view of the current scan position.
//
// Signalling: there is no valid/ready handshake on this bus. value and blank
// are plain levels. value is only sampled on the frame boundary edge. blank
// takes effect on the next edge. frame_done is a single-cycle strobe that
// marks the cycle after a new snapshot was taken.
interface hex_display_mux_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value;
  logic                    blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  logic [IW-1:0]           dig_idx;

  modport master (
    output value, blank,
    input  seg, an, frame_done, dig_idx
  );

  modport slave (
    input  value, blank,
    output seg, an, frame_done, dig_idx
  );
endinterface

// File: rtl/hex_display_mux.sv
// Multiplexed 7-segment hex display driver. A prescaler steps through the
// digits, the input count is snapshotted once per frame so that a frame never
// mixes two values, and each digit switch inserts one dark cycle to avoid
// ghosting. All board-facing outputs are registered.
module hex_display_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  hex_display_mux_if.slave bus
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [DW-1:0]           div_cnt;
  logic [IW-1:0]           dig_idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;

  logic                    tick;
  logic                    last_digit;
  logic [3:0]              cur_nib;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    lz_acc;

  // Active-low g..a decode of one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot timing, current-digit nibble select and leading-zero detection.
  always_comb begin
    tick       = (div_cnt == DW'(REFRESH_DIV - 1));
    last_digit = (dig_idx == IW'(NUM_DIGITS - 1));
    cur_nib    = 4'h0;
    cur_lz     = 1'b0;
    lz         = '0;
    lz_acc     = 1'b1;
    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 always shows so a zero count reads "0".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_acc = lz_acc & (snap[4*i +: 4] == 4'h0);
      lz[i]  = (i > 0) & lz_acc;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == IW'(i)) begin
        cur_nib = snap[4*i +: 4];
        cur_lz  = lz[i];
      end
    end
  end

  // Prescaler, scan position, per-frame snapshot and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      dig_idx      <= '0;
      snap         <= '0;
      an_q         <= ALL_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= tick & last_digit;
      if (tick) begin
        div_cnt <= '0;
        dig_idx <= last_digit ? '0 : dig_idx + 1'b1;
        if (last_digit) begin
          snap <= bus.value;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (tick) begin
        // Dead cycle between digits; segments hold unless blanking.
        an_q <= ALL_OFF;
        if (bus.blank) begin
          seg_q <= SEG_OFF;
        end
      end else if (bus.blank || (LZ_BLANK && cur_lz)) begin
        an_q  <= ALL_OFF;
        seg_q <= SEG_OFF;
      end else begin
        an_q  <= ~(ONE_HOT0 << dig_idx);
        seg_q <= decode(cur_nib);
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.dig_idx    = dig_idx;
endmodule
